// File: rtl/imm_pkg.sv
// Shared encodings for the immediate encoder: format selectors, fixed RV32I
// opcodes used by the LI expansion, FSM state encoding and a range helper.
package imm_pkg;

    localparam logic [2:0] I_TYPE = 3'b000;
    localparam logic [2:0] S_TYPE = 3'b001;
    localparam logic [2:0] B_TYPE = 3'b010;
    localparam logic [2:0] J_TYPE = 3'b011;
    localparam logic [2:0] U_TYPE = 3'b100;
    localparam logic [2:0] LI_OP  = 3'b101;

    localparam logic [6:0] OPC_LUI     = 7'b0110111;
    localparam logic [6:0] OPC_OP_IMM  = 7'b0010011;
    localparam logic [2:0] FUNCT3_ADDI = 3'b000;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        EMIT1 = 2'b01,
        EMIT2 = 2'b10
    } state_e;

    // True when v is representable as a 12-bit signed value.
    function automatic logic fits_simm12(input logic [31:0] v);
        return (v[31:11] == {21{v[11]}});
    endfunction

endpackage

// File: rtl/imm_encoder_if.sv
// Request/response stream bundle of the immediate encoder. The slave view is
// the encoder itself; the master view drives requests and consumes words.
interface imm_encoder_if;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_op;
    logic [6:0]  in_opcode;
    logic [2:0]  in_funct3;
    logic [4:0]  in_rd;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic [31:0] in_imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic        out_err;
    logic        rt_fail;

    modport master (
        output in_valid, in_op, in_opcode, in_funct3, in_rd, in_rs1, in_rs2, in_imm,
        output out_ready,
        input  in_ready, out_valid, out_instr, out_err, rt_fail
    );

    modport slave (
        input  in_valid, in_op, in_opcode, in_funct3, in_rd, in_rs1, in_rs2, in_imm,
        input  out_ready,
        output in_ready, out_valid, out_instr, out_err, rt_fail
    );
endinterface

// File: rtl/imm_extend.sv
// Immediate extender used only by the optional round-trip checker
// (IMM_ROUNDTRIP_CHECK_EN); immsrc shares the packer's format encoding.
`ifdef IMM_ROUNDTRIP_CHECK_EN
module imm_extend
    import imm_pkg::*;
(
    input  logic [31:7] instr,
    input  logic [2:0]  immsrc,
    output logic [31:0] immext
);

    // Reassemble and sign-extend the immediate for each format.
    always_comb begin
        immext = 32'h0000_0000;
        case (immsrc)
            I_TYPE:  immext = {{20{instr[31]}}, instr[31:20]};
            S_TYPE:  immext = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            B_TYPE:  immext = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            J_TYPE:  immext = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            U_TYPE:  immext = {instr[31:12], 12'h000};
            default: immext = 32'h0000_0000;
        endcase
    end

endmodule
`endif

// File: rtl/imm_pack.sv
// Combinational RV32I field packer with immediate range/alignment checking.
// Reserved format selectors produce an all-zero word flagged as an error.
module imm_pack
    import imm_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [31:0] imm,
    output logic [31:0] instr,
    output logic        err
);

    // Field placement and error detection per format.
    always_comb begin
        instr = 32'h0000_0000;
        err   = 1'b0;
        case (op)
            I_TYPE: begin
                instr = {imm[11:0], rs1, funct3, rd, opcode};
                err   = !fits_simm12(imm);
            end
            S_TYPE: begin
                instr = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
                err   = !fits_simm12(imm);
            end
            B_TYPE: begin
                instr = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
                err   = (imm[31:12] != {20{imm[12]}}) || imm[0];
            end
            J_TYPE: begin
                instr = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
                err   = (imm[31:20] != {12{imm[20]}}) || imm[0];
            end
            U_TYPE: begin
                instr = {imm[31:12], rd, opcode};
                err   = (imm[11:0] != 12'h000);
            end
            default: begin
                instr = 32'h0000_0000;
                err   = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/imm_encoder.sv
// RV32I immediate encoder with LI expansion (ADDI, LUI or LUI+ADDI).
// Optional round-trip self-check enabled by defining IMM_ROUNDTRIP_CHECK_EN.
module imm_encoder
    import imm_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    imm_encoder_if.slave bus
);

    state_e      state_r;
    state_e      state_nx_s;
    logic        load_first_s;
    logic        load_second_s;
    logic        retire_s;

    logic        in_ready_r;
    logic        out_valid_r;
    logic [31:0] out_instr_r;
    logic        out_err_r;

    logic        need_second_r;
    logic [4:0]  second_rd_r;
    logic [11:0] second_lo_r;

    logic [19:0] li_hi_s;
    logic        li_fits_s;

    logic [2:0]  pk_op_s;
    logic [6:0]  pk_opcode_s;
    logic [2:0]  pk_funct3_s;
    logic [4:0]  pk_rd_s;
    logic [4:0]  pk_rs1_s;
    logic [4:0]  pk_rs2_s;
    logic [31:0] pk_imm_s;
    logic [31:0] pk_instr_s;
    logic        pk_err_s;

    // Rounding the upper part by imm[11] compensates for ADDI sign-extending lo.
    assign li_hi_s   = bus.in_imm[31:12] + {19'b0, bus.in_imm[11]};
    assign li_fits_s = fits_simm12(bus.in_imm);

    // Packer input select: pending ADDI outside IDLE, else the incoming request.
    always_comb begin
        pk_op_s     = bus.in_op;
        pk_opcode_s = bus.in_opcode;
        pk_funct3_s = bus.in_funct3;
        pk_rd_s     = bus.in_rd;
        pk_rs1_s    = bus.in_rs1;
        pk_rs2_s    = bus.in_rs2;
        pk_imm_s    = bus.in_imm;
        if (state_r != IDLE) begin
            pk_op_s     = I_TYPE;
            pk_opcode_s = OPC_OP_IMM;
            pk_funct3_s = FUNCT3_ADDI;
            pk_rd_s     = second_rd_r;
            pk_rs1_s    = second_rd_r;
            pk_rs2_s    = 5'd0;
            pk_imm_s    = {{20{second_lo_r[11]}}, second_lo_r};
        end else if (bus.in_op == LI_OP) begin
            pk_rs1_s = 5'd0;
            pk_rs2_s = 5'd0;
            if (li_fits_s) begin
                pk_op_s     = I_TYPE;
                pk_opcode_s = OPC_OP_IMM;
                pk_funct3_s = FUNCT3_ADDI;
                pk_imm_s    = bus.in_imm;
            end else begin
                pk_op_s     = U_TYPE;
                pk_opcode_s = OPC_LUI;
                pk_funct3_s = 3'b000;
                pk_imm_s    = {li_hi_s, 12'h000};
            end
        end else begin
            pk_op_s = bus.in_op;
        end
    end

    imm_pack u_pack (
        .op     (pk_op_s),
        .opcode (pk_opcode_s),
        .funct3 (pk_funct3_s),
        .rd     (pk_rd_s),
        .rs1    (pk_rs1_s),
        .rs2    (pk_rs2_s),
        .imm    (pk_imm_s),
        .instr  (pk_instr_s),
        .err    (pk_err_s)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state and load/retire strobes.
    always_comb begin
        state_nx_s    = state_r;
        load_first_s  = 1'b0;
        load_second_s = 1'b0;
        retire_s      = 1'b0;
        case (state_r)
            IDLE: begin
                if (bus.in_valid) begin
                    load_first_s = 1'b1;
                    state_nx_s   = EMIT1;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            EMIT1: begin
                if (bus.out_ready) begin
                    if (need_second_r) begin
                        load_second_s = 1'b1;
                        state_nx_s    = EMIT2;
                    end else begin
                        retire_s   = 1'b1;
                        state_nx_s = IDLE;
                    end
                end else begin
                    state_nx_s = EMIT1;
                end
            end
            EMIT2: begin
                if (bus.out_ready) begin
                    retire_s   = 1'b1;
                    state_nx_s = IDLE;
                end else begin
                    state_nx_s = EMIT2;
                end
            end
            default: begin
                retire_s   = 1'b1;
                state_nx_s = IDLE;
            end
        endcase
    end

    // Output word registers; held while the consumer stalls.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            out_instr_r <= 32'h0000_0000;
            out_err_r   <= 1'b0;
        end else begin
            in_ready_r <= (state_nx_s == IDLE);
            if (load_first_s || load_second_s) begin
                out_valid_r <= 1'b1;
                out_instr_r <= pk_instr_s;
                out_err_r   <= pk_err_s;
            end else if (retire_s) begin
                out_valid_r <= 1'b0;
            end else begin
                out_valid_r <= out_valid_r;
            end
        end
    end

    // Pending ADDI bookkeeping for two-word LI sequences.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            need_second_r <= 1'b0;
            second_rd_r   <= 5'd0;
            second_lo_r   <= 12'h000;
        end else if (load_first_s) begin
            need_second_r <= (bus.in_op == LI_OP) && !li_fits_s && (bus.in_imm[11:0] != 12'h000);
            second_rd_r   <= bus.in_rd;
            second_lo_r   <= bus.in_imm[11:0];
        end else if (load_second_s) begin
            need_second_r <= 1'b0;
        end else begin
            need_second_r <= need_second_r;
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.out_instr = out_instr_r;
    assign bus.out_err   = out_err_r;

`ifdef IMM_ROUNDTRIP_CHECK_EN
    logic [31:0] exp_imm_r;
    logic [2:0]  exp_src_r;
    logic [31:0] dec_imm_s;
    logic        rt_fail_r;

    imm_extend u_ext (
        .instr  (out_instr_r[31:7]),
        .immsrc (exp_src_r),
        .immext (dec_imm_s)
    );

    // Capture the immediate each emitted word must decode back to.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            exp_imm_r <= 32'h0000_0000;
            exp_src_r <= I_TYPE;
        end else if (load_first_s || load_second_s) begin
            exp_imm_r <= pk_imm_s;
            exp_src_r <= pk_op_s;
        end else begin
            exp_imm_r <= exp_imm_r;
        end
    end

    // Sticky round-trip mismatch flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rt_fail_r <= 1'b0;
        end else if (out_valid_r && !out_err_r && (dec_imm_s != exp_imm_r)) begin
            rt_fail_r <= 1'b1;
        end else begin
            rt_fail_r <= rt_fail_r;
        end
    end

    assign bus.rt_fail = rt_fail_r;
`else
    assign bus.rt_fail = 1'b0;
`endif

endmodule

// File: tb/tb_imm_encoder.sv
// Directed-vector bench for imm_encoder with hand-computed instruction words.
module tb_imm_encoder;
    import imm_pkg::*;

    logic clk;
    logic reset;
    int   vec_cnt;
    int   miss_cnt;

    imm_encoder_if bus ();

    imm_encoder dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            miss_cnt++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic send(input string tag, input logic [2:0] op, input logic [6:0] opc,
                        input logic [2:0] f3, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [31:0] imm);
        int n;
        bus.in_op     = op;
        bus.in_opcode = opc;
        bus.in_funct3 = f3;
        bus.in_rd     = rd;
        bus.in_rs1    = rs1;
        bus.in_rs2    = rs2;
        bus.in_imm    = imm;
        bus.in_valid  = 1'b1;
        n = 0;
        while (!bus.in_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check_eq({tag, ".in_ready"}, {31'b0, bus.in_ready}, 32'd1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        check_eq({tag, ".lat1"}, {31'b0, bus.out_valid}, 32'd1);
    endtask

    task automatic get_word(input string tag, input logic [31:0] exp_instr, input logic exp_err);
        int n;
        n = 0;
        while (!bus.out_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check_eq({tag, ".valid"}, {31'b0, bus.out_valid}, 32'd1);
        check_eq({tag, ".instr"}, bus.out_instr, exp_instr);
        check_eq({tag, ".err"}, {31'b0, bus.out_err}, {31'b0, exp_err});
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic expect_idle(input string tag);
        check_eq({tag, ".done_valid"}, {31'b0, bus.out_valid}, 32'd0);
        check_eq({tag, ".done_ready"}, {31'b0, bus.in_ready}, 32'd1);
    endtask

    initial begin
        vec_cnt       = 0;
        miss_cnt      = 0;
        reset         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_op     = 3'b000;
        bus.in_opcode = 7'd0;
        bus.in_funct3 = 3'd0;
        bus.in_rd     = 5'd0;
        bus.in_rs1    = 5'd0;
        bus.in_rs2    = 5'd0;
        bus.in_imm    = 32'd0;
        bus.out_ready = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check_eq("rst.valid", {31'b0, bus.out_valid}, 32'd0);
        check_eq("rst.instr", bus.out_instr, 32'h0000_0000);
        check_eq("rst.err", {31'b0, bus.out_err}, 32'd0);
        check_eq("rst.in_ready", {31'b0, bus.in_ready}, 32'd1);
        check_eq("rst.rt_fail", {31'b0, bus.rt_fail}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;

        // I-type ADDI x1,x0,-1
        send("i_neg1", I_TYPE, 7'b0010011, 3'b000, 5'd1, 5'd0, 5'd0, 32'hFFFF_FFFF);
        check_eq("i_neg1.busy", {31'b0, bus.in_ready}, 32'd0);
        get_word("i_neg1", 32'hFFF0_0093, 1'b0);
        expect_idle("i_neg1");

        // B-type, offset -4, then odd offset 3
        send("b_neg4", B_TYPE, 7'b1100011, 3'b000, 5'd0, 5'd0, 5'd0, 32'hFFFF_FFFC);
        get_word("b_neg4", 32'hFE00_0EE3, 1'b0);
        send("b_odd", B_TYPE, 7'b1100011, 3'b000, 5'd0, 5'd0, 5'd0, 32'h0000_0003);
        get_word("b_odd", 32'h0000_0163, 1'b1);

        // S-type, J-type and I-type overflow
        send("s_neg8", S_TYPE, 7'b0100011, 3'b010, 5'd0, 5'd2, 5'd3, 32'hFFFF_FFF8);
        get_word("s_neg8", 32'hFE31_2C23, 1'b0);
        send("j_2048", J_TYPE, 7'b1101111, 3'b000, 5'd1, 5'd0, 5'd0, 32'h0000_0800);
        get_word("j_2048", 32'h0010_00EF, 1'b0);
        send("i_ovf", I_TYPE, 7'b0010011, 3'b000, 5'd1, 5'd0, 5'd0, 32'h0000_0800);
        get_word("i_ovf", 32'h8000_0093, 1'b1);

        // LI needing LUI+ADDI
        send("li2", LI_OP, 7'd0, 3'd0, 5'd5, 5'd0, 5'd0, 32'h1234_5FFF);
        check_eq("li2.busy1", {31'b0, bus.in_ready}, 32'd0);
        get_word("li2.w1", 32'h1234_62B7, 1'b0);
        check_eq("li2.busy2", {31'b0, bus.in_ready}, 32'd0);
        get_word("li2.w2", 32'hFFF2_8293, 1'b0);
        expect_idle("li2");

        // LI single-word forms
        send("li_lui", LI_OP, 7'd0, 3'd0, 5'd1, 5'd0, 5'd0, 32'h0000_1000);
        get_word("li_lui", 32'h0000_10B7, 1'b0);
        expect_idle("li_lui");
        send("li_addi", LI_OP, 7'd0, 3'd0, 5'd2, 5'd0, 5'd0, 32'hFFFF_FFFB);
        get_word("li_addi", 32'hFFB0_0113, 1'b0);
        expect_idle("li_addi");

        // LI with consumer stalled on the first word
        send("li_stall", LI_OP, 7'd0, 3'd0, 5'd5, 5'd0, 5'd0, 32'h1234_5FFF);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check_eq("li_stall.hold", bus.out_instr, 32'h1234_62B7);
            check_eq("li_stall.hold_v", {31'b0, bus.out_valid}, 32'd1);
        end
        get_word("li_stall.w1", 32'h1234_62B7, 1'b0);
        get_word("li_stall.w2", 32'hFFF2_8293, 1'b0);

        // Reset while the pending ADDI is on the output
        send("li_rst", LI_OP, 7'd0, 3'd0, 5'd5, 5'd0, 5'd0, 32'h1234_5FFF);
        get_word("li_rst.w1", 32'h1234_62B7, 1'b0);
        check_eq("li_rst.emit2", bus.out_instr, 32'hFFF2_8293);
        reset = 1'b0;
        #1;
        check_eq("li_rst.valid", {31'b0, bus.out_valid}, 32'd0);
        check_eq("li_rst.instr", bus.out_instr, 32'h0000_0000);
        check_eq("li_rst.in_ready", {31'b0, bus.in_ready}, 32'd1);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        send("after_rst", I_TYPE, 7'b0010011, 3'b000, 5'd1, 5'd0, 5'd0, 32'hFFFF_FFFF);
        get_word("after_rst", 32'hFFF0_0093, 1'b0);
        expect_idle("after_rst");

        // U-type with nonzero low bits, and a reserved op
        send("u_low", U_TYPE, 7'b0110111, 3'd0, 5'd3, 5'd0, 5'd0, 32'h0000_1001);
        get_word("u_low", 32'h0000_11B7, 1'b1);
        send("rsvd", 3'b110, 7'b0010011, 3'd0, 5'd1, 5'd1, 5'd1, 32'h0000_0001);
        get_word("rsvd", 32'h0000_0000, 1'b1);
        expect_idle("rsvd");

        check_eq("rt_fail", {31'b0, bus.rt_fail}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule

// File: doc/imm_encoder.md
Name: imm_encoder

Overview:
- Inverse of the immediate extender: packs a signed/unsigned 32-bit immediate plus register/funct fields into a 32-bit RV32I instruction word.
- Also expands the LI pseudo-op into a one- or two-instruction sequence: ADDI, LUI, or LUI+ADDI.
- Sits between the in-system assembler/test-program generator and instruction memory. Uses a valid/ready stream on both sides.

Parameters:
- none (fixed RV32I encodings)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- in_valid  in  1  request valid
- in_ready  out  1  request accepted when in_valid & in_ready at clk edge
- in_op  in  3  000 I, 001 S, 010 B, 011 J, 100 U, 101 LI; 110/111 reserved
- in_opcode  in  7  opcode[6:0], ignored for LI
- in_funct3  in  3  funct3, used by I/S/B only
- in_rd  in  5  rd for I/J/U/LI
- in_rs1  in  5  rs1 for I/S/B
- in_rs2  in  5  rs2 for S/B
- in_imm  in  32  immediate as a signed byte offset/value; for U, the full 32-bit value
- out_valid  out  1  instruction word valid
- out_ready  in  1  consumer accepts the word
- out_instr  out  32  encoded instruction
- out_err  out  1  range/alignment/reserved-op error for this word
- rt_fail  out  1  sticky round-trip mismatch flag (optional feature only)

Behaviour:
- Reset (async assert, sync release): state=IDLE; out_valid=0, out_instr=0, out_err=0, rt_fail=0, in_ready=1.
- FSM states: IDLE, EMIT1, EMIT2. in_ready=1 only in IDLE.
- IDLE + accept: register the request and the encoded first word. out_valid=1 the next cycle (latency 1). Go to EMIT1.
- EMIT1 + out_ready:
  - LI needing a second word: load the ADDI word, go to EMIT2, out_valid stays 1.
  - Otherwise: out_valid=0, go to IDLE.
- EMIT2 + out_ready: out_valid=0, go to IDLE. No new request is accepted in the same cycle (one bubble per request).
- While out_valid=1 and out_ready=0, out_instr and out_err hold stable.
- Field placement (RISC-V standard):
  - I: imm[11:0]→[31:20]; rs1[19:15]; funct3[14:12]; rd[11:7].
  - S: imm[11:5]→[31:25]; rs2[24:20]; rs1; funct3; imm[4:0]→[11:7].
  - B: imm[12]→31; imm[10:5]→30:25; rs2; rs1; funct3; imm[4:1]→11:8; imm[11]→7.
  - J: imm[20]→31; imm[10:1]→30:21; imm[11]→20; imm[19:12]→19:12; rd.
  - U: imm[31:12]→[31:12]; rd.
  - opcode→[6:0] in all formats.
- Error rules (word still emitted with truncated fields, out_err=1):
  - I/S: imm outside [-2048, 2047].
  - B: outside [-4096, 4094] or imm[0]=1.
  - J: outside [-2^20, 2^20-2] or imm[0]=1.
  - U: imm[11:0]≠0.
  - Reserved op: out_instr=0, out_err=1, single word.
- LI expansion:
  - If imm fits in 12 bits signed: one word, ADDI rd,x0,imm (opcode 0010011, funct3 000).
  - Else: hi=(imm+32'h800)[31:12] with wrap-around allowed (no error), lo=imm[11:0].
    - Word 1: LUI rd,hi (opcode 0110111).
    - Word 2, only if lo≠0: ADDI rd,rd,sext(lo).
  - LI never sets out_err. rd=x0 is legal and encoded as given.
- Reset mid-sequence (EMIT1/EMIT2): all outputs return to reset values and the pending ADDI is discarded.

Optional Feature:
- Macro IMM_ROUNDTRIP_CHECK_EN.
- With the macro: an imm_extend instance decodes out_instr using the matching immsrc (LI words use I/U). Whenever out_valid=1 and out_err=0, the decoded value is compared to the expected immediate (request imm, or hi<<12 / sext(lo) for LI). On mismatch rt_fail sets and stays set until reset.
- Without the macro: rt_fail is tied to 0 and no checker logic is present.

Decomposition:
- Package imm_pkg holds:
  - op codes I_TYPE..U_TYPE, identical to the extender's immsrc encoding, plus LI_OP=3'b101.
  - OPC_LUI=7'b0110111, OPC_OP_IMM=7'b0010011, FUNCT3_ADDI=3'b000.
  - State encoding.
- Sub-module imm_pack: combinational field packer plus range checker (op, fields, imm → instr, err). It is instantiated once, and the FSM reuses it for the LI words.

Test Plan:
- I: opcode 0010011, rd=1, rs1=0, funct3=0, imm=-1 → out_instr 32'hFFF00093, out_err=0, out_valid one cycle after accept.
- B: opcode 1100011, rs1=rs2=0, funct3=0, imm=-4 → 32'hFE000EE3. Same request with imm=3 → out_err=1.
- LI rd=5, imm=32'h12345FFF → 32'h123462B7, then 32'hFFF28293, with in_ready=0 throughout.
- LI rd=1, imm=32'h00001000 → single word 32'h000010B7. LI rd=2, imm=-5 → single word 32'hFFB00113.
- LI rd=5, imm=32'h12345FFF with out_ready held 0 for 3 cycles → first word stable; second word appears only after the handshake.
- Assert reset during EMIT2 → out_valid=0 immediately, FSM returns to IDLE, next request encodes correctly. U with imm=32'h00001001 → out_err=1.
